// File: rtl/mem_stage_mc_pkg.sv
// mem_stage_mc_pkg: load/store encodings, FSM states and the request record shared by the memory stage.
package mem_stage_mc_pkg;
    localparam int XLEN_MAX = 64;
    localparam int ADDR_MAX = 64;
    localparam int MW_MAX = 8;
    localparam logic [2:0] load_f3_lb = 3'd0;
    localparam logic [2:0] load_f3_lh = 3'd1;
    localparam logic [2:0] load_f3_lw = 3'd2;
    localparam logic [2:0] load_f3_ld = 3'd3;
    localparam logic [2:0] load_f3_lbu = 3'd4;
    localparam logic [2:0] load_f3_lhu = 3'd5;
    localparam logic [2:0] load_f3_lwu = 3'd6;
    localparam logic [2:0] store_f3_sd = 3'd3;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_fsm_t;

    typedef struct packed {
        logic [ADDR_MAX-1:0] addr;
        logic [MW_MAX-1:0]   rmask;
        logic [MW_MAX-1:0]   wmask;
        logic [XLEN_MAX-1:0] wdata;
        logic [2:0]          funct3;
        logic                fault;
    } mem_req_t;

    function automatic logic access_fault(input logic re, input logic we, input logic is64,
                                          input logic [2:0] f3, input logic [2:0] off);
        logic misaligned;
        logic bad_f3;
        misaligned = f3[1:0] == 2'd1 ? off[0] : f3[1:0] == 2'd2 ? |off[1:0] : f3[1:0] == 2'd3 ? |off : 1'b0;
        bad_f3 = re ? (f3 == 3'd7 || (!is64 && (f3 == load_f3_ld || f3 == load_f3_lwu)))
                    : (f3[2] || (!is64 && f3 == store_f3_sd));
        return (re && we) || bad_f3 || misaligned;
    endfunction
endpackage

// File: rtl/mem_stage_mc_load_align.sv
// load_align: shifts raw read data down to the addressed byte and extends it per funct3.
module load_align
    import mem_stage_mc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OB = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [OB-1:0]   off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);
    logic [XLEN-1:0] sh;
    assign sh = rdata >> {off, 3'b000};
    assign result = funct3 == load_f3_lb  ? XLEN'($signed(sh[7:0]))
                  : funct3 == load_f3_lh  ? XLEN'($signed(sh[15:0]))
                  : funct3 == load_f3_lw  ? XLEN'($signed(sh[31:0]))
                  : funct3 == load_f3_lbu ? XLEN'(sh[7:0])
                  : funct3 == load_f3_lhu ? XLEN'(sh[15:0])
                  : funct3 == load_f3_lwu ? XLEN'(sh[31:0])
                  : sh;
endmodule

// File: rtl/mem_stage_mc.sv
// mem_stage_mc: pipeline memory stage with alignment checks, byte-lane steering and a
// variable-latency dmem handshake that stalls upstream while an access is in flight.
module mem_stage_mc
    import mem_stage_mc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_re,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              stall,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN/8-1:0] dmem_rmask,
    output logic [XLEN/8-1:0] dmem_wmask,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_resp,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_rdata,
    output logic              out_fault,
    output logic [ADDR_W-1:0] out_addr,
    output logic [XLEN/8-1:0] out_rmask,
    output logic [XLEN/8-1:0] out_wmask,
    output logic [XLEN-1:0]   out_wdata
);
    localparam int MW = XLEN / 8;
    localparam int OB = $clog2(MW);

    mem_fsm_t state, state_nx;
    mem_req_t req_q;
    logic [OB-1:0] off, off_q;
    logic [XLEN-1:0] rdata_q, load_res, wdata_rep;
    logic [MW-1:0] mask;
    logic mem_op, fault, unused_req;

    assign mem_op = req_valid & (req_re | req_we);
    assign off = req_addr[OB-1:0];
    assign fault = access_fault(req_re, req_we, XLEN == 64, req_funct3, 3'(off));
    assign mask = (req_funct3[1:0] == 2'd0 ? MW'(1) : req_funct3[1:0] == 2'd1 ? MW'(3)
                 : req_funct3[1:0] == 2'd2 ? MW'(15) : '1) << off;
    // Replicating the low bytes puts the store data on every lane the mask might select.
    assign wdata_rep = (req_funct3[1:0] == 2'd0 ? {MW{req_wdata[7:0]}}
                      : req_funct3[1:0] == 2'd1 ? {(MW/2){req_wdata[15:0]}}
                      : req_funct3[1:0] == 2'd2 ? {(MW/4){req_wdata[31:0]}}
                      : req_wdata) << {off, 3'b000};

    load_align #(.XLEN(XLEN), .OB(OB)) u_load_align (
        .rdata (dmem_rdata),
        .off   (off_q),
        .funct3(req_q.funct3),
        .result(load_res)
    );

    always_comb begin
        state_nx = IDLE;
        stall = 1'b0;
        if (state == IDLE) begin
            state_nx = mem_op ? (fault ? DONE : BUSY) : IDLE;
            stall = mem_op;
        end else if (state == BUSY) begin
            state_nx = dmem_resp ? DONE : BUSY;
            stall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            req_q <= '0;
            off_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && mem_op) begin
                req_q.addr <= ADDR_MAX'({req_addr[ADDR_W-1:OB], OB'(0)});
                req_q.rmask <= MW_MAX'(req_re && !fault ? mask : '0);
                req_q.wmask <= MW_MAX'(req_we && !fault ? mask : '0);
                req_q.wdata <= XLEN_MAX'(wdata_rep);
                req_q.funct3 <= req_funct3;
                req_q.fault <= fault;
                off_q <= off;
                rdata_q <= '0;
            end
            if (state == BUSY && dmem_resp)
                rdata_q <= req_q.rmask != '0 ? load_res : '0;
        end
    end

    assign dmem_addr = req_q.addr[ADDR_W-1:0];
    assign dmem_rmask = state == BUSY ? req_q.rmask[MW-1:0] : '0;
    assign dmem_wmask = state == BUSY ? req_q.wmask[MW-1:0] : '0;
    assign dmem_wdata = req_q.wdata[XLEN-1:0];
    assign out_valid = state == DONE;
    assign out_fault = out_valid & req_q.fault;
    assign out_rdata = rdata_q;
    assign out_addr = req_q.addr[ADDR_W-1:0];
    assign out_rmask = req_q.rmask[MW-1:0];
    assign out_wmask = req_q.wmask[MW-1:0];
    assign out_wdata = req_q.wdata[XLEN-1:0];
    assign unused_req = ^req_q;
endmodule

// File: tb/tb_mem_stage_mc.sv
// tb_mem_stage_mc: table-driven, hand-sequenced and randomized checks of mem_stage_mc at XLEN=32 and XLEN=64.
module tb_mem_stage_mc;
    logic clk = 0, rst = 0;
    logic v32 = 0, v64 = 0, re = 0, we = 0, resp = 0;
    logic [2:0] f3 = 0;
    logic [31:0] addr = 0;
    logic [63:0] wdata = 0, rdata = 0;
    logic st32, ov32, of32, st64, ov64, of64;
    logic [31:0] da32, oa32, dw32, or32, ow32, da64, oa64;
    logic [63:0] dw64, or64, ow64;
    logic [3:0] rm32, wm32, orm32, owm32;
    logic [7:0] rm64, wm64, orm64, owm64;
    int checks = 0, errors = 0, pulses = 0;

    typedef struct {
        bit is64; bit re; bit we; logic [2:0] f3; logic [31:0] addr;
        logic [63:0] wd; logic [63:0] rd; int lat;
        bit fault; logic [7:0] mask; logic [63:0] res;
    } vec_t;

    always #5 clk = ~clk;
    always @(posedge clk) pulses <= pulses + int'(ov32) + int'(ov64);

    mem_stage_mc #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst(rst), .req_valid(v32), .req_re(re), .req_we(we), .req_funct3(f3),
        .req_addr(addr), .req_wdata(wdata[31:0]), .stall(st32), .dmem_addr(da32),
        .dmem_rmask(rm32), .dmem_wmask(wm32), .dmem_wdata(dw32), .dmem_rdata(rdata[31:0]),
        .dmem_resp(resp), .out_valid(ov32), .out_rdata(or32), .out_fault(of32),
        .out_addr(oa32), .out_rmask(orm32), .out_wmask(owm32), .out_wdata(ow32)
    );

    mem_stage_mc #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst), .req_valid(v64), .req_re(re), .req_we(we), .req_funct3(f3),
        .req_addr(addr), .req_wdata(wdata), .stall(st64), .dmem_addr(da64),
        .dmem_rmask(rm64), .dmem_wmask(wm64), .dmem_wdata(dw64), .dmem_rdata(rdata),
        .dmem_resp(resp), .out_valid(ov64), .out_rdata(or64), .out_fault(of64),
        .out_addr(oa64), .out_rmask(orm64), .out_wmask(owm64), .out_wdata(ow64)
    );

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", n, got, exp);
        end
    endtask

    // Reference: access size, lane mask and extended load value from the ISA rules.
    function automatic vec_t model(input vec_t v);
        int mw = v.is64 ? 8 : 4;
        int off = int'(v.addr % 32'(mw));
        int nb = 1 << v.f3[1:0];
        logic [63:0] rd = v.is64 ? v.rd : {32'h0, v.rd[31:0]};
        logic [63:0] val = rd >> (8 * off);
        logic [63:0] lim = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 * nb)) - 64'd1;
        v.fault = (v.re && v.we)
               || (v.re ? (v.f3 == 3'd7 || (!v.is64 && (v.f3 == 3'd3 || v.f3 == 3'd6)))
                        : (v.f3 > 3'd3 || (!v.is64 && v.f3 == 3'd3)))
               || (off % nb != 0);
        v.mask = v.fault ? 8'h0 : 8'(((16'd1 << nb) - 16'd1) << off);
        val = val & lim;
        if (v.f3 < 3'd3 && val[8 * nb - 1]) val = val | ~lim;
        if (!v.is64) val[63:32] = 32'h0;
        v.res = (v.fault || !v.re) ? 64'h0 : val;
        return v;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int mw = v.is64 ? 8 : 4;
        int off = int'(v.addr % 32'(mw));
        logic [31:0] al = v.addr & ~(32'(mw) - 32'd1);
        int done_at = v.fault ? 1 : v.lat + 1;
        int seen = -1;
        bit stall_ok = 1, mask_ok = 1, addr_ok = 1, wd_ok = 1, busy;
        logic st, f;
        logic [7:0] rm, wm, orm, owm;
        logic [31:0] da;
        logic [63:0] dw, r;
        v32 = !v.is64; v64 = v.is64; re = v.re; we = v.we; f3 = v.f3;
        addr = v.addr; wdata = v.wd; rdata = v.rd;
        for (int c = 0; c < 40 && seen < 0; c++) begin
            resp = !v.fault && c == v.lat;
            #1;
            st = v.is64 ? st64 : st32;
            rm = v.is64 ? rm64 : {4'h0, rm32};
            wm = v.is64 ? wm64 : {4'h0, wm32};
            da = v.is64 ? da64 : da32;
            dw = v.is64 ? dw64 : {32'h0, dw32};
            busy = !v.fault && c >= 1 && c <= v.lat;
            if (st !== (c < done_at)) stall_ok = 0;
            if (rm !== ((busy && v.re) ? v.mask : 8'h0) || wm !== ((busy && v.we) ? v.mask : 8'h0)) mask_ok = 0;
            if (busy && da !== al) addr_ok = 0;
            if (busy && v.we)
                for (int i = 0; i < mw; i++)
                    if (v.mask[i] && dw[8 * i +: 8] !== v.wd[8 * (i - off) +: 8]) wd_ok = 0;
            if ((v.is64 ? ov64 : ov32) === 1'b1) begin
                seen = c;
                f = v.is64 ? of64 : of32;
                r = v.is64 ? or64 : {32'h0, or32};
                orm = v.is64 ? orm64 : {4'h0, orm32};
                owm = v.is64 ? owm64 : {4'h0, owm32};
            end
            @(negedge clk);
        end
        resp = 0;
        chk({tag, " valid_cycle"}, 64'(seen), 64'(done_at));
        chk({tag, " stall"}, 64'(stall_ok), 64'd1);
        chk({tag, " dmem_mask"}, 64'(mask_ok), 64'd1);
        chk({tag, " dmem_addr"}, 64'(addr_ok), 64'd1);
        chk({tag, " dmem_wdata"}, 64'(wd_ok), 64'd1);
        chk({tag, " out_fault"}, 64'(f), 64'(v.fault));
        chk({tag, " out_rdata"}, r, v.res);
        chk({tag, " out_rmask"}, 64'(orm), 64'(v.re ? v.mask : 8'h0));
        chk({tag, " out_wmask"}, 64'(owm), 64'(v.we ? v.mask : 8'h0));
    endtask

    task automatic idle(input bit nonmem);
        v32 = nonmem; v64 = nonmem; re = 0; we = 0; resp = 0;
        #1;
        chk("idle_stall", 64'({st32, st64}), 64'd0);
        chk("idle_valid", 64'({ov32, ov64}), 64'd0);
        @(negedge clk);
        v32 = 0; v64 = 0;
    endtask

    initial begin
        vec_t tbl[16];
        vec_t v;
        int p0, r;
        tbl[0]  = '{0, 1, 0, 3'd0, 32'h1003, 64'h0, 64'h8000_0000, 3, 0, 8'h08, 64'hFFFF_FF80};
        tbl[1]  = '{0, 0, 1, 3'd1, 32'h2002, 64'h1234_ABCD, 64'h0, 1, 0, 8'h0C, 64'h0};
        tbl[2]  = '{0, 1, 0, 3'd2, 32'h3001, 64'h0, 64'h0, 1, 1, 8'h00, 64'h0};
        tbl[3]  = '{1, 1, 0, 3'd6, 32'h4004, 64'h0, 64'h8000_0000_0000_0000, 2, 0, 8'hF0, 64'h0000_0000_8000_0000};
        tbl[4]  = '{1, 1, 0, 3'd3, 32'h4008, 64'h0, 64'h0123_4567_89AB_CDEF, 2, 0, 8'hFF, 64'h0123_4567_89AB_CDEF};
        tbl[5]  = '{0, 1, 0, 3'd3, 32'h0010, 64'h0, 64'h0, 1, 1, 8'h00, 64'h0};
        tbl[6]  = '{0, 0, 1, 3'd3, 32'h0010, 64'h55, 64'h0, 1, 1, 8'h00, 64'h0};
        tbl[7]  = '{0, 1, 1, 3'd2, 32'h0020, 64'h0, 64'h0, 1, 1, 8'h00, 64'h0};
        tbl[8]  = '{0, 1, 0, 3'd5, 32'h0002, 64'h0, 64'h80FF_0000, 2, 0, 8'h0C, 64'h0000_80FF};
        tbl[9]  = '{1, 1, 0, 3'd2, 32'h0004, 64'h0, 64'h8000_0000_0000_0000, 1, 0, 8'hF0, 64'hFFFF_FFFF_8000_0000};
        tbl[10] = '{0, 0, 1, 3'd0, 32'h0005, 64'hAB, 64'h0, 1, 0, 8'h02, 64'h0};
        tbl[11] = '{0, 0, 1, 3'd4, 32'h0000, 64'h0, 64'h0, 1, 1, 8'h00, 64'h0};
        tbl[12] = '{1, 0, 1, 3'd2, 32'h0002, 64'h0, 64'h0, 1, 1, 8'h00, 64'h0};
        tbl[13] = '{0, 1, 0, 3'd2, 32'h0008, 64'h0, 64'hDEAD_BEEF, 4, 0, 8'h0F, 64'hDEAD_BEEF};
        tbl[14] = '{1, 0, 1, 3'd3, 32'h0008, 64'h1122_3344_5566_7788, 64'h0, 3, 0, 8'hFF, 64'h0};
        tbl[15] = '{1, 1, 0, 3'd1, 32'h0006, 64'h0, 64'h8001_0000_0000_0000, 2, 0, 8'hC0, 64'hFFFF_FFFF_FFFF_8001};
        repeat (2) @(negedge clk);
        rst = 1;
        #1;
        chk("reset_stall", 64'({st32, st64}), 64'd0);
        chk("reset_masks", 64'({rm32, wm32, rm64, wm64}), 64'd0);
        chk("reset_valid", 64'({ov32, ov64, of32, of64}), 64'd0);
        chk("reset_regs", {or32, oa32} | or64 | {oa64, ow32} | ow64, 64'd0);
        @(negedge clk);
        foreach (tbl[i]) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
            idle(i[0]);
        end
        p0 = pulses;
        v = '{0, 1, 0, 3'd2, 32'h200, 64'h0, 64'h1122_3344, 2, 0, 8'h0F, 64'h1122_3344};
        run_op(v, "b2b_lw");
        v = '{0, 0, 1, 3'd2, 32'h204, 64'hCAFE_F00D, 64'h0, 1, 0, 8'h0F, 64'h0};
        run_op(v, "b2b_sw");
        chk("b2b_pulses", 64'(pulses - p0), 64'd2);
        idle(0);
        v32 = 1; re = 1; we = 0; f3 = 3'd2; addr = 32'h100; resp = 0;
        @(negedge clk);
        #1;
        chk("rst_busy_mask", 64'(rm32), 64'hF);
        rst = 0;
        @(negedge clk);
        rst = 1; v32 = 0; re = 0;
        #1;
        chk("rst_mask_clear", 64'({rm32, wm32}), 64'd0);
        chk("rst_stall", 64'(st32), 64'd0);
        p0 = pulses;
        @(negedge clk);
        resp = 1;
        @(negedge clk);
        resp = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_no_valid", 64'(pulses - p0), 64'd0);
        chk("rst_mask_idle", 64'(rm32), 64'd0);
        @(negedge clk);
        for (int n = 0; n < 80; n++) begin
            v.is64 = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            v.re = r < 5 || r == 9;
            v.we = r >= 5;
            v.f3 = 3'($urandom_range(0, 7));
            if (v.we && $urandom_range(0, 3) != 0) v.f3[2] = 1'b0;
            v.addr = $urandom;
            if ($urandom_range(0, 2) != 0) v.addr = v.addr & ~((32'd1 << v.f3[1:0]) - 32'd1);
            v.wd = {$urandom, $urandom};
            v.rd = {$urandom, $urandom};
            v.lat = int'($urandom_range(1, 4));
            v = model(v);
            run_op(v, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) != 0) idle(1'($urandom_range(0, 1)));
        end
        idle(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage_mc.md
Name: mem_stage_mc

Overview:
- Next-generation pipeline memory stage. Sits between the EX/MEM and MEM/WB pipeline registers.
- Generalised over data width: XLEN=32 or 64, covering RV32I and RV64I loads and stores.
- Supports variable-latency data memory through a dmem_resp handshake and stalls upstream while a memory access is outstanding.
- Checks alignment, and shifts, sign-extends or zero-extends load data before writeback.

Parameters:
- XLEN, 32, data width; legal values are 32 or 64. Define MW = XLEN/8 (mask width) and OB = log2(MW) (byte-offset bits).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- req_valid  in  1  EX/MEM register holds a valid instruction
- req_re  in  1  instruction is a load
- req_we  in  1  instruction is a store
- req_funct3  in  3  load/store funct3
- req_addr  in  ADDR_W  effective address (ALU output)
- req_wdata  in  XLEN  rs2 value
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- dmem_addr  out  ADDR_W  access address, aligned to MW bytes
- dmem_rmask  out  MW  byte read mask
- dmem_wmask  out  MW  byte write mask
- dmem_wdata  out  XLEN  lane-shifted store data
- dmem_rdata  in  XLEN  raw read data
- dmem_resp  in  1  memory done; single-cycle pulse
- out_valid  out  1  one-cycle pulse: memory op complete
- out_rdata  out  XLEN  extended load result; 0 for stores and faults
- out_fault  out  1  misaligned or illegal access; qualified by out_valid
- out_addr, out_rmask, out_wmask, out_wdata  out  ADDR_W/MW/MW/XLEN  registered copies of the issued request, for RVFI logging

Behaviour:
- Definitions:
  - mem_op = req_valid & (req_re | req_we).
  - off = req_addr[OB-1:0].
- FSM states: IDLE, BUSY, DONE.
- Reset (rst=0 at a clock edge):
  - state goes to IDLE.
  - All request and output registers clear to 0.
  - dmem masks are 0 from the next cycle; stall=0.
- IDLE:
  - stall = mem_op, combinational.
  - If mem_op and the access is legal: latch the aligned address, masks and wdata into the request register, then go to BUSY.
  - If mem_op and the access is a fault: go to DONE with fault=1, issuing no dmem request.
  - Non-memory ops: no stall and no out_valid.
- BUSY:
  - dmem_addr, dmem_rmask, dmem_wmask and dmem_wdata are driven from the request register and held stable.
  - stall=1.
  - On dmem_resp: latch the extended load result and go to DONE.
  - A dmem_resp may arrive in the first BUSY cycle (minimum latency 1).
- DONE:
  - out_valid=1, stall=0, dmem masks 0.
  - EX/MEM advances at the end of this cycle; the state always returns to IDLE.
  - Inputs seen during DONE are never accepted. This costs one bubble per memory op.
- Outside BUSY, all dmem masks are 0 and dmem_resp is ignored.
- Masks:
  - b/bu: 1<<off
  - h/hu: 3<<off
  - w/wu: 0xF<<off
  - d: all ones
- Store data: req_wdata shifted left by 8*off, with the low bytes replicated per size.
- Load result:
  - Take dmem_rdata >> 8*off.
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - lw sign-extends when XLEN=64.
  - lwu zero-extends; ld passes through.
- Faults:
  - h with off[0]≠0.
  - w with off[1:0]≠0.
  - d with off≠0.
  - ld, lwu or sd when XLEN=32.
  - req_re and req_we both set.
  - Reserved funct3.
- If rst is asserted mid-BUSY, the access is abandoned and a later dmem_resp produces no out_valid.

Decomposition:
- Added to the shared rv32i_types package:
  - load_f3_ld, load_f3_lwu, store_f3_sd.
  - mem_fsm_t enum {IDLE, BUSY, DONE}.
  - mem_req_t struct {addr, rmask, wmask, wdata, funct3, fault}.
- One combinational sub-module, load_align: inputs (rdata, off, funct3), output the extended result.

Test Plan:
- XLEN=32, lb at 0x1003, dmem_resp in the 3rd BUSY cycle with rdata 0x80000000:
  - dmem_addr=0x1000, rmask=4'b1000.
  - stall high for cycles 0–3.
  - out_valid in cycle 4 with out_rdata=0xFFFFFF80.
- sh at 0x2002 with rs2=0x1234ABCD, resp in cycle 1:
  - wmask=4'b1100, dmem_wdata[31:16]=0xABCD.
  - out_valid cycle 2, out_rdata=0.
- lw at 0x3001:
  - No dmem mask ever nonzero.
  - out_valid and out_fault both 1 in cycle 1.
- XLEN=64, lwu at 0x4004 with rdata 0x80000000_00000000:
  - rmask=8'hF0, out_rdata=0x00000000_80000000.
- XLEN=64, ld at 0x4008:
  - dmem_addr=0x4008, rmask=8'hFF.
- rst=0 during BUSY, then dmem_resp 2 cycles later:
  - Masks are 0 the next cycle and no out_valid follows.
- Back-to-back lw then sw:
  - stall=0 only in each DONE cycle.
  - The sw is accepted in the cycle after the lw's DONE, and exactly 2 out_valid pulses occur.
